seg_scan_capture: RTL

- Reader/monitor for the multiplexed 4-digit 7-segment display bus driven by the board top level: digit strobes D1..D4 plus segment lines D_out1..D_out8.
- Follows the scan, waits for each strobe to settle, samples the segments, and decodes them back to hex nibbles, decimal point (dp), blank and error flags.
- Raises a frame-complete pulse once all four digits are captured.
- Used as an on-chip self-check and as the capture end in benches for display-driving blocks.

---
 rtl/seg_scan_capture.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: reader/monitor for a multiplexed 4-digit 7-segment display bus.
// Follows the digit scan, waits for each strobe/pattern to settle, captures the
// segments and decodes them back to hex nibbles plus dp/blank/error flags.
// Optional feature macro: SEG_CHANGE_DETECT_EN adds the CHANGED output and a
// 28-bit shadow of the last completed frame.
module seg_scan_capture #(
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned SETTLE     = 4,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [3:0]  DIG,
  input  logic [7:0]  SEG,
  output logic [15:0] HEX,
  output logic [3:0]  DP,
  output logic [3:0]  BLANK,
  output logic [3:0]  ERR,
  output logic        FRAME_VALID,
  output logic        FRAME_DONE,
  output logic        SCAN_ERR,
  output logic        STALE
`ifdef SEG_CHANGE_DETECT_EN
  ,
  output logic        CHANGED
`endif
);

  localparam int unsigned   TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT);
  localparam logic [TW-1:0] TLAST    = TW'(TIMEOUT - 1);
  localparam logic [7:0]    SLAST    = 8'(SETTLE - 1);
  // Idle bus level, so the synchroniser does not fake a multi-strobe after reset
  localparam logic [3:0]    DIG_IDLE = {4{ACTIVE_LOW}};
  localparam logic [7:0]    SEG_IDLE = {8{ACTIVE_LOW}};

  typedef enum logic [1:0] {StIdle, StSettle, StCapture, StHold} state_t;

  // Returns {blank, err, nibble} for a gfedcba pattern
  function automatic logic [5:0] seg_decode(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b0;
    case (p)
      7'h3F:   r[3:0] = 4'h0;
      7'h06:   r[3:0] = 4'h1;
      7'h5B:   r[3:0] = 4'h2;
      7'h4F:   r[3:0] = 4'h3;
      7'h66:   r[3:0] = 4'h4;
      7'h6D:   r[3:0] = 4'h5;
      7'h7D:   r[3:0] = 4'h6;
      7'h07:   r[3:0] = 4'h7;
      7'h7F:   r[3:0] = 4'h8;
      7'h6F:   r[3:0] = 4'h9;
      7'h77:   r[3:0] = 4'hA;
      7'h7C:   r[3:0] = 4'hB;
      7'h39:   r[3:0] = 4'hC;
      7'h5E:   r[3:0] = 4'hD;
      7'h79:   r[3:0] = 4'hE;
      7'h71:   r[3:0] = 4'hF;
      7'h00:   r[5]   = 1'b1;
      default: r[4]   = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [2:0] pop4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

  logic [3:0]    dig_s1, dig_s2;
  logic [7:0]    seg_s1, seg_s2;
  logic [3:0]    dig_n;
  logic [7:0]    seg_n;
  logic [2:0]    dig_cnt;

  state_t        state_q;
  logic [3:0]    lat_dig_q;
  logic [7:0]    lat_seg_q;
  logic [7:0]    settle_q;
  logic [TW-1:0] tmo_q;
  logic [3:0]    seen_q;

  logic [1:0]    lat_idx;
  logic [5:0]    dec;
  logic [15:0]   hex_nx;
  logic [3:0]    dp_nx;
  logic [3:0]    blank_nx;
  logic [3:0]    err_nx;
  logic [3:0]    seen_nx;

`ifdef SEG_CHANGE_DETECT_EN
  logic [27:0]   shadow_q;
  logic          shadow_vld_q;
  logic [27:0]   frame_nx;
`endif

  // Two-flop synchroniser on the asynchronous display bus
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dig_s1 <= DIG_IDLE;
      dig_s2 <= DIG_IDLE;
      seg_s1 <= SEG_IDLE;
      seg_s2 <= SEG_IDLE;
    end else begin
      dig_s1 <= DIG;
      dig_s2 <= dig_s1;
      seg_s1 <= SEG;
      seg_s2 <= seg_s1;
    end
  end

  // Polarity normalisation to active-high
  always_comb begin
    dig_n   = dig_s2 ^ DIG_IDLE;
    seg_n   = seg_s2 ^ SEG_IDLE;
    dig_cnt = pop4(dig_n);
  end

  // Index of the latched one-hot strobe
  always_comb begin
    lat_idx = 2'd0;
    case (lat_dig_q)
      4'b0010: lat_idx = 2'd1;
      4'b0100: lat_idx = 2'd2;
      4'b1000: lat_idx = 2'd3;
      default: lat_idx = 2'd0;
    endcase
  end

  // Output values after writing the latched digit (used in CAPTURE)
  always_comb begin
    dec      = seg_decode(lat_seg_q[6:0]);
    hex_nx   = HEX;
    dp_nx    = DP;
    blank_nx = BLANK;
    err_nx   = ERR;
    hex_nx[{lat_idx, 2'b00} +: 4] = dec[3:0];
    dp_nx[lat_idx]    = lat_seg_q[7];
    blank_nx[lat_idx] = dec[5];
    err_nx[lat_idx]   = dec[4];
    seen_nx  = seen_q | lat_dig_q;
`ifdef SEG_CHANGE_DETECT_EN
    frame_nx = {hex_nx, dp_nx, blank_nx, err_nx};
`endif
  end

  // Scan FSM, frame tracking and timeout with registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= StIdle;
      lat_dig_q    <= 4'b0;
      lat_seg_q    <= 8'b0;
      settle_q     <= 8'b0;
      tmo_q        <= '0;
      seen_q       <= 4'b0;
      HEX          <= 16'b0;
      DP           <= 4'b0;
      BLANK        <= 4'b0;
      ERR          <= 4'b0;
      FRAME_VALID  <= 1'b0;
      FRAME_DONE   <= 1'b0;
      SCAN_ERR     <= 1'b0;
      STALE        <= 1'b0;
`ifdef SEG_CHANGE_DETECT_EN
      CHANGED      <= 1'b0;
      shadow_q     <= 28'b0;
      shadow_vld_q <= 1'b0;
`endif
    end else begin
      FRAME_DONE <= 1'b0;
`ifdef SEG_CHANGE_DETECT_EN
      CHANGED    <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          if (dig_cnt == 3'd1) begin
            state_q   <= StSettle;
            lat_dig_q <= dig_n;
            lat_seg_q <= seg_n;
            settle_q  <= 8'b0;
          end else if (dig_cnt > 3'd1) begin
            SCAN_ERR <= 1'b1;
          end
        end
        StSettle: begin
          if (dig_n != lat_dig_q || seg_n != lat_seg_q) begin
            // Any change restarts the settle window on the new value
            if (dig_cnt == 3'd1) begin
              lat_dig_q <= dig_n;
              lat_seg_q <= seg_n;
              settle_q  <= 8'b0;
            end else begin
              state_q <= StIdle;
            end
          end else if (settle_q == SLAST) begin
            state_q <= StCapture;
          end else begin
            settle_q <= settle_q + 8'd1;
          end
        end
        StCapture: begin
          HEX     <= hex_nx;
          DP      <= dp_nx;
          BLANK   <= blank_nx;
          ERR     <= err_nx;
          STALE   <= 1'b0;
          tmo_q   <= '0;
          state_q <= StHold;
          if (seen_nx == 4'hF) begin
            FRAME_DONE  <= 1'b1;
            FRAME_VALID <= 1'b1;
            seen_q      <= 4'b0;
`ifdef SEG_CHANGE_DETECT_EN
            CHANGED      <= !shadow_vld_q || (frame_nx != shadow_q);
            shadow_q     <= frame_nx;
            shadow_vld_q <= 1'b1;
`endif
          end else begin
            seen_q <= seen_nx;
          end
        end
        StHold: begin
          // Leave only once the strobe moves, so one strobe period captures once
          if (dig_n != lat_dig_q) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Saturating timeout; CAPTURE never counts, so a capture beats expiry
      if (state_q != StCapture && tmo_q != TMAX) begin
        tmo_q <= tmo_q + TW'(1);
        if (tmo_q == TLAST) begin
          STALE       <= 1'b1;
          FRAME_VALID <= 1'b0;
          seen_q      <= 4'b0;
`ifdef SEG_CHANGE_DETECT_EN
          shadow_vld_q <= 1'b0;
`endif
        end
      end
    end
  end

endmodule
